// File: rtl/control_unit_if.sv
// ---------------------------------------------------------------------------
// control_unit_if
// Bundles the signals that pass between the control unit and the datapath.
//
// Signals
//   ir          [31:0] current instruction register contents (datapath -> cu)
//   stop               request to halt at the next instruction boundary
//   PCout .. IRin, Yin datapath control strobes (cu -> datapath)
//   Gra, Grb, Grc      register-field selects (Ra/Rb/Rc fields of ir)
//   Rin, Rout          gated write / drive enables for the selected register
//   alu_op      [4:0]  ALU operation code
//   run                high while the sequencer is executing instructions
//   instr_count [15:0] number of completed instructions
//
// Modports
//   master : the control unit (drives strobes, consumes ir/stop)
//   slave  : the datapath / environment (drives ir/stop, consumes strobes)
// ---------------------------------------------------------------------------
interface control_unit_if;
    logic [31:0] ir;
    logic        stop;

    logic        PCout;
    logic        MARin;
    logic        IncPC;
    logic        Zin;
    logic        Zlowout;
    logic        PCin;
    logic        Read;
    logic        MDRin;
    logic        MDRout;
    logic        IRin;
    logic        Yin;

    logic        Gra;
    logic        Grb;
    logic        Grc;
    logic        Rin;
    logic        Rout;

    logic [4:0]  alu_op;
    logic        run;
    logic [15:0] instr_count;

    modport master (
        input  ir, stop,
        output PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin,
               MDRout, IRin, Yin, Gra, Grb, Grc, Rin, Rout,
               alu_op, run, instr_count
    );

    modport slave (
        output ir, stop,
        input  PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin,
               MDRout, IRin, Yin, Gra, Grb, Grc, Rin, Rout,
               alu_op, run, instr_count
    );
endinterface

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Hard-wired sequencer for a small register-register CPU. Each instruction
// is fetched in T0..T2; three-operand ALU ops (add/sub/and/or) execute in
// T3..T5 as  Y <- R[rb];  Z <- Y op R[rc];  R[ra] <- Zlow.  Unknown opcodes
// act as no-ops and finish in T2; the halt opcode parks the sequencer in
// HALT until the next reset.
//
// Ports
//   clk  : system clock, all state changes on the rising edge
//   clr  : synchronous active-high reset (forces RST, clears instr_count)
//   cu   : control_unit_if.master bundle (ir/stop in, strobes/alu_op/run/
//          instr_count out)
//
// All strobes, alu_op and run are Moore outputs decoded from the state
// register (and ir for alu_op in T4). instr_count is a registered counter.
// ---------------------------------------------------------------------------
module control_unit (
    input  logic           clk,
    input  logic           clr,
    control_unit_if.master cu
);

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_T5   = 3'd6,
        ST_HALT = 3'd7
    } state_e;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // True for the opcodes that take the T3..T5 execute path.
    function automatic logic is_alu_op(input logic [4:0] op);
        logic hit;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: hit = 1'b1;
            default:                       hit = 1'b0;
        endcase
        return hit;
    endfunction

    state_e      state_q;
    state_e      state_d;
    logic [15:0] instr_count_q;
    logic [15:0] instr_count_d;
    logic        complete_s;
    logic [4:0]  opcode_s;

    assign opcode_s = cu.ir[31:27];

    // Next-state logic; also flags the cycle in which an instruction retires.
    always_comb begin
        state_d    = state_q;
        complete_s = 1'b0;
        case (state_q)
            ST_RST: state_d = ST_T0;
            ST_T0:  state_d = ST_T1;
            ST_T1:  state_d = ST_T2;
            ST_T2: begin
                if (is_alu_op(opcode_s)) begin
                    state_d = ST_T3;
                end else if (opcode_s == OP_HALT) begin
                    // halt is not counted as a completed instruction
                    state_d = ST_HALT;
                end else begin
                    // no-op retires here; stop is honoured only at retirement
                    complete_s = 1'b1;
                    state_d    = cu.stop ? ST_HALT : ST_T0;
                end
            end
            ST_T3:  state_d = ST_T4;
            ST_T4:  state_d = ST_T5;
            ST_T5: begin
                complete_s = 1'b1;
                state_d    = cu.stop ? ST_HALT : ST_T0;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    // Retired-instruction counter; 16-bit add wraps FFFF -> 0000 naturally.
    always_comb begin
        if (complete_s) begin
            instr_count_d = instr_count_q + 16'd1;
        end else begin
            instr_count_d = instr_count_q;
        end
    end

    // State and counter registers with synchronous clear taking priority.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= ST_RST;
            instr_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Moore output decode: every strobe defaults low, each state raises its own.
    always_comb begin
        cu.PCout   = 1'b0;
        cu.MARin   = 1'b0;
        cu.IncPC   = 1'b0;
        cu.Zin     = 1'b0;
        cu.Zlowout = 1'b0;
        cu.PCin    = 1'b0;
        cu.Read    = 1'b0;
        cu.MDRin   = 1'b0;
        cu.MDRout  = 1'b0;
        cu.IRin    = 1'b0;
        cu.Yin     = 1'b0;
        cu.Gra     = 1'b0;
        cu.Grb     = 1'b0;
        cu.Grc     = 1'b0;
        cu.Rin     = 1'b0;
        cu.Rout    = 1'b0;
        cu.alu_op  = 5'b00000;
        cu.run     = 1'b0;
        case (state_q)
            ST_RST: begin
                cu.run = 1'b0;
            end
            ST_T0: begin
                cu.run   = 1'b1;
                cu.PCout = 1'b1;
                cu.MARin = 1'b1;
                cu.IncPC = 1'b1;
                cu.Zin   = 1'b1;
            end
            ST_T1: begin
                cu.run     = 1'b1;
                cu.Zlowout = 1'b1;
                cu.PCin    = 1'b1;
                cu.Read    = 1'b1;
                cu.MDRin   = 1'b1;
            end
            ST_T2: begin
                cu.run    = 1'b1;
                cu.MDRout = 1'b1;
                cu.IRin   = 1'b1;
            end
            ST_T3: begin
                cu.run  = 1'b1;
                cu.Grb  = 1'b1;
                cu.Rout = 1'b1;
                cu.Yin  = 1'b1;
            end
            ST_T4: begin
                cu.run    = 1'b1;
                cu.Grc    = 1'b1;
                cu.Rout   = 1'b1;
                cu.Zin    = 1'b1;
                cu.alu_op = opcode_s;
            end
            ST_T5: begin
                cu.run     = 1'b1;
                cu.Zlowout = 1'b1;
                cu.Gra     = 1'b1;
                cu.Rin     = 1'b1;
            end
            ST_HALT: begin
                cu.run = 1'b0;
            end
            default: begin
                cu.run = 1'b0;
            end
        endcase
    end

    assign cu.instr_count = instr_count_q;

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
// Directed bench for control_unit. Outputs are packed into one vector
// {16 strobes, alu_op, run} and compared with hand-written per-state
// constants. Inputs change 2 ns after the rising edge; outputs are checked
// at the same point, once combinational decode has settled.
// ---------------------------------------------------------------------------
module tb_control_unit;

    logic clk = 1'b0;
    logic clr = 1'b1;

    always #5 clk = ~clk;

    control_unit_if bus();

    control_unit dut (
        .clk (clk),
        .clr (clr),
        .cu  (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [2:0] S_RST  = 3'd0;
    localparam logic [2:0] S_T0   = 3'd1;
    localparam logic [2:0] S_T1   = 3'd2;
    localparam logic [2:0] S_T2   = 3'd3;
    localparam logic [2:0] S_T3   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;
    localparam logic [2:0] S_T5   = 3'd6;
    localparam logic [2:0] S_HALT = 3'd7;

    localparam logic [31:0] IR_AND  = 32'h28918000;
    localparam logic [31:0] IR_ADD  = 32'h18918000;
    localparam logic [31:0] IR_SUB  = 32'h20918000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;
    localparam logic [31:0] IR_NOP  = 32'h00000000;

    // Strobe order: PCout MARin IncPC Zin Zlowout PCin Read MDRin
    //               MDRout IRin Yin Gra Grb Grc Rin Rout
    function automatic logic [21:0] exp_vec(input logic [2:0] st, input logic [4:0] op);
        logic [15:0] s;
        logic [4:0]  a;
        logic        r;
        a = 5'b00000;
        r = 1'b1;
        case (st)
            S_T0:    s = 16'hF000;
            S_T1:    s = 16'h0F00;
            S_T2:    s = 16'h00C0;
            S_T3:    s = 16'h0029;
            S_T4:    begin s = 16'h1005; a = op; end
            S_T5:    s = 16'h0812;
            default: begin s = 16'h0000; r = 1'b0; end
        endcase
        return {s, a, r};
    endfunction

    function automatic logic [21:0] dut_vec();
        return {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.Zlowout, bus.PCin,
                bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.Gra,
                bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.alu_op, bus.run};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Pulse clr for one edge; returns with the FSM in T0.
    task automatic do_reset();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bus.ir   = IR_NOP;
        bus.stop = 1'b0;
        clr      = 1'b1;
        tick();
        tick();
        n_total++;
        if (dut_vec() !== exp_vec(S_RST, 5'b00000)) begin
            $display("FAIL reset_outputs: got %h expected %h", dut_vec(), exp_vec(S_RST, 5'b00000));
        end else n_pass++;
        n_total++;
        if (bus.instr_count !== 16'h0000) begin
            $display("FAIL reset_count: got %h expected 0000", bus.instr_count);
        end else n_pass++;
        clr = 1'b0;
        tick();
        n_total++;
        if (dut_vec() !== exp_vec(S_T0, 5'b00000)) begin
            $display("FAIL reset_exit_t0: got %h expected %h", dut_vec(), exp_vec(S_T0, 5'b00000));
        end else n_pass++;
    endtask

    task automatic test_and_seq();
        logic [2:0]  seq [0:6] = '{S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T0};
        logic [15:0] cnt [0:6] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
        bus.ir   = IR_AND;
        bus.stop = 1'b0;
        clr      = 1'b1;
        tick();
        n_total++;
        if (dut_vec() !== exp_vec(S_RST, 5'b00000) || bus.instr_count !== 16'h0000) begin
            $display("FAIL and_rst: got %h/%h expected %h/0000", dut_vec(), bus.instr_count, exp_vec(S_RST, 5'b00000));
        end else n_pass++;
        clr = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_total++;
            if (dut_vec() !== exp_vec(seq[i], 5'b00101)) begin
                $display("FAIL and_seq step %0d: got %h expected %h", i, dut_vec(), exp_vec(seq[i], 5'b00101));
            end else n_pass++;
            n_total++;
            if (bus.instr_count !== cnt[i]) begin
                $display("FAIL and_count step %0d: got %h expected %h", i, bus.instr_count, cnt[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_noop();
        logic [2:0]  seq [0:5] = '{S_T1, S_T2, S_T0, S_T1, S_T2, S_T0};
        logic [15:0] cnt [0:5] = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd2};
        bus.ir   = IR_NOP;
        bus.stop = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            n_total++;
            if (dut_vec() !== exp_vec(seq[i], 5'b00000)) begin
                $display("FAIL noop_seq step %0d: got %h expected %h", i, dut_vec(), exp_vec(seq[i], 5'b00000));
            end else n_pass++;
            n_total++;
            if (bus.instr_count !== cnt[i]) begin
                $display("FAIL noop_count step %0d: got %h expected %h", i, bus.instr_count, cnt[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_stop();
        // stop high during T5 -> HALT after the ADD retires
        bus.ir   = IR_ADD;
        bus.stop = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        n_total++;
        if (dut_vec() !== exp_vec(S_T5, 5'b00011)) begin
            $display("FAIL stop_t5: got %h expected %h", dut_vec(), exp_vec(S_T5, 5'b00011));
        end else n_pass++;
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (dut_vec() !== exp_vec(S_HALT, 5'b00000) || bus.instr_count !== 16'h0001) begin
                $display("FAIL stop_halt cycle %0d: got %h/%h expected %h/0001", i, dut_vec(), bus.instr_count, exp_vec(S_HALT, 5'b00000));
            end else n_pass++;
            tick();
        end

        // stop pulse confined to T3 is ignored
        do_reset();
        tick();
        tick();
        tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        n_total++;
        if (dut_vec() !== exp_vec(S_T4, 5'b00011)) begin
            $display("FAIL stop_pulse_t4: got %h expected %h", dut_vec(), exp_vec(S_T4, 5'b00011));
        end else n_pass++;
        tick();
        tick();
        n_total++;
        if (dut_vec() !== exp_vec(S_T0, 5'b00000) || bus.instr_count !== 16'h0001) begin
            $display("FAIL stop_pulse_t0: got %h/%h expected %h/0001", dut_vec(), bus.instr_count, exp_vec(S_T0, 5'b00000));
        end else n_pass++;

        // stop at a no-op's completion in T2
        bus.ir = IR_NOP;
        do_reset();
        tick();
        tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        n_total++;
        if (dut_vec() !== exp_vec(S_HALT, 5'b00000) || bus.instr_count !== 16'h0001) begin
            $display("FAIL stop_noop: got %h/%h expected %h/0001", dut_vec(), bus.instr_count, exp_vec(S_HALT, 5'b00000));
        end else n_pass++;
    endtask

    task automatic test_halt();
        bus.ir   = IR_NOP;
        bus.stop = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        bus.ir = IR_HALT;
        tick();
        tick();
        n_total++;
        if (dut_vec() !== exp_vec(S_T2, 5'b00000)) begin
            $display("FAIL halt_t2: got %h expected %h", dut_vec(), exp_vec(S_T2, 5'b00000));
        end else n_pass++;
        tick();
        for (int i = 0; i < 12; i++) begin
            n_total++;
            if (dut_vec() !== exp_vec(S_HALT, 5'b00000) || bus.instr_count !== 16'h0001) begin
                $display("FAIL halt_hold cycle %0d: got %h/%h expected %h/0001", i, dut_vec(), bus.instr_count, exp_vec(S_HALT, 5'b00000));
            end else n_pass++;
            bus.stop = i[0];
            tick();
        end
        bus.stop = 1'b0;
        clr      = 1'b1;
        tick();
        clr      = 1'b0;
        n_total++;
        if (dut_vec() !== exp_vec(S_RST, 5'b00000) || bus.instr_count !== 16'h0000) begin
            $display("FAIL halt_clr: got %h/%h expected %h/0000", dut_vec(), bus.instr_count, exp_vec(S_RST, 5'b00000));
        end else n_pass++;
        tick();
        n_total++;
        if (dut_vec() !== exp_vec(S_T0, 5'b00000)) begin
            $display("FAIL halt_resume: got %h expected %h", dut_vec(), exp_vec(S_T0, 5'b00000));
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.ir   = IR_ADD;
        bus.stop = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        n_total++;
        if (dut_vec() !== exp_vec(S_T4, 5'b00011) || bus.instr_count !== 16'h0001) begin
            $display("FAIL mid_t4: got %h/%h expected %h/0001", dut_vec(), bus.instr_count, exp_vec(S_T4, 5'b00011));
        end else n_pass++;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_total++;
        if (dut_vec() !== exp_vec(S_RST, 5'b00000) || bus.instr_count !== 16'h0000) begin
            $display("FAIL mid_rst: got %h/%h expected %h/0000", dut_vec(), bus.instr_count, exp_vec(S_RST, 5'b00000));
        end else n_pass++;
        tick();
        n_total++;
        if (dut_vec() !== exp_vec(S_T0, 5'b00000)) begin
            $display("FAIL mid_t0: got %h expected %h", dut_vec(), exp_vec(S_T0, 5'b00000));
        end else n_pass++;
        tick();
        n_total++;
        if (dut_vec() !== exp_vec(S_T1, 5'b00000)) begin
            $display("FAIL mid_t1: got %h expected %h", dut_vec(), exp_vec(S_T1, 5'b00000));
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        bus.ir   = IR_AND;
        bus.stop = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        tick();
        n_total++;
        if (dut_vec() !== exp_vec(S_T4, 5'b00101)) begin
            $display("FAIL b2b_and_t4: got %h expected %h", dut_vec(), exp_vec(S_T4, 5'b00101));
        end else n_pass++;
        tick();
        tick();
        // garbage opcode while fetching must not be decoded
        bus.ir = IR_HALT;
        tick();
        bus.ir = IR_SUB;
        tick();
        tick();
        n_total++;
        if (dut_vec() !== exp_vec(S_T3, 5'b00000)) begin
            $display("FAIL b2b_sub_t3: got %h expected %h", dut_vec(), exp_vec(S_T3, 5'b00000));
        end else n_pass++;
        tick();
        n_total++;
        if (dut_vec() !== exp_vec(S_T4, 5'b00100)) begin
            $display("FAIL b2b_sub_t4: got %h expected %h", dut_vec(), exp_vec(S_T4, 5'b00100));
        end else n_pass++;
        tick();
        tick();
        n_total++;
        if (dut_vec() !== exp_vec(S_T0, 5'b00000) || bus.instr_count !== 16'h0002) begin
            $display("FAIL b2b_done: got %h/%h expected %h/0002", dut_vec(), bus.instr_count, exp_vec(S_T0, 5'b00000));
        end else n_pass++;
    endtask

    task automatic test_wrap();
        bus.ir   = IR_NOP;
        bus.stop = 1'b0;
        do_reset();
        force dut.instr_count_q = 16'hFFFE;
        #1;
        release dut.instr_count_q;
        n_total++;
        if (bus.instr_count !== 16'hFFFE) begin
            $display("FAIL wrap_preload: got %h expected fffe", bus.instr_count);
        end else n_pass++;
        tick();
        tick();
        tick();
        n_total++;
        if (bus.instr_count !== 16'hFFFF) begin
            $display("FAIL wrap_ffff: got %h expected ffff", bus.instr_count);
        end else n_pass++;
        tick();
        tick();
        tick();
        n_total++;
        if (bus.instr_count !== 16'h0000 || dut_vec() !== exp_vec(S_T0, 5'b00000)) begin
            $display("FAIL wrap_zero: got %h/%h expected 0000/%h", bus.instr_count, dut_vec(), exp_vec(S_T0, 5'b00000));
        end else n_pass++;
    endtask

    initial begin
        bus.ir   = IR_NOP;
        bus.stop = 1'b0;
        test_reset();
        test_and_seq();
        test_noop();
        test_stop();
        test_halt();
        test_reset_mid();
        test_back_to_back();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
